// File: rtl/hpdmc_wrseq_pkg.sv
// Shared definitions for the DDR write-path sequencer.
// State encodings and counter widths.
package hpdmc_wrseq_pkg;

    localparam int WRSEQ_LAT_W  = 4;
    localparam int WRSEQ_BEAT_W = 3;

    typedef enum logic [2:0] {
        WRSEQ_IDLE = 3'd0,
        WRSEQ_WAIT = 3'd1,
        WRSEQ_PRE  = 3'd2,
        WRSEQ_DATA = 3'd3,
        WRSEQ_POST = 3'd4
    } wrseq_state_t;

endpackage

// File: rtl/hpdmc_wrseq.sv
// DDR write-path sequencer: write latency, DQS preamble/burst/postamble,
// and registered D0/D1 + output-enable feeds for the PHY ODDR banks.
module hpdmc_wrseq
    import hpdmc_wrseq_pkg::*;
#(
    parameter int BYTES        = 4,
    parameter int WL           = 2,
    parameter int BURST_CYCLES = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 write_start,
    output logic                 write_ready,
    output logic                 write_busy,
    output logic                 overlap_err,
    input  logic [16*BYTES-1:0]  di,
    input  logic [2*BYTES-1:0]   dmi,
    output logic                 di_ack,
    output logic [8*BYTES-1:0]   dq_d0,
    output logic [8*BYTES-1:0]   dq_d1,
    output logic [BYTES-1:0]     dm_d0,
    output logic [BYTES-1:0]     dm_d1,
    output logic [BYTES-1:0]     dqs_d0,
    output logic [BYTES-1:0]     dqs_d1,
    output logic                 dq_oe,
    output logic                 dqs_oe
);

    localparam logic [WRSEQ_LAT_W-1:0]  LAT_LOAD  = WRSEQ_LAT_W'(WL - 1);
    localparam logic [WRSEQ_BEAT_W-1:0] BEAT_LOAD = WRSEQ_BEAT_W'(BURST_CYCLES - 1);

    wrseq_state_t              state, state_n;
    logic [WRSEQ_LAT_W-1:0]    lat, lat_n;
    logic [WRSEQ_BEAT_W-1:0]   beat, beat_n;
    logic                      ack_n;

    always_comb begin
        state_n = state;
        lat_n   = lat;
        beat_n  = beat;
        unique case (state)
            WRSEQ_IDLE: begin
                if (write_start) begin
                    lat_n   = LAT_LOAD;
                    state_n = (WL > 1) ? WRSEQ_WAIT : WRSEQ_PRE;
                end
            end
            WRSEQ_WAIT: begin
                lat_n = lat - WRSEQ_LAT_W'(1);
                if (lat_n == '0)
                    state_n = WRSEQ_PRE;
            end
            WRSEQ_PRE: begin
                beat_n  = BEAT_LOAD;
                state_n = WRSEQ_DATA;
            end
            WRSEQ_DATA: begin
                if (beat == '0)
                    state_n = WRSEQ_POST;
                else
                    beat_n = beat - WRSEQ_BEAT_W'(1);
            end
            WRSEQ_POST: begin
                state_n = WRSEQ_IDLE;
                if (write_start) begin
                    lat_n   = LAT_LOAD;
                    state_n = (WL > 1) ? WRSEQ_WAIT : WRSEQ_PRE;
                end
            end
            default: state_n = WRSEQ_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it.
    assign ack_n = (state_n == WRSEQ_PRE) ||
                   ((state_n == WRSEQ_DATA) && (beat_n != '0));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= WRSEQ_IDLE;
            lat         <= '0;
            beat        <= '0;
            write_ready <= 1'b1;
            write_busy  <= 1'b0;
            overlap_err <= 1'b0;
            di_ack      <= 1'b0;
            dq_d0       <= '0;
            dq_d1       <= '0;
            dm_d0       <= '1;
            dm_d1       <= '1;
            dqs_d0      <= '0;
            dqs_d1      <= '0;
            dq_oe       <= 1'b0;
            dqs_oe      <= 1'b0;
        end else begin
            state       <= state_n;
            lat         <= lat_n;
            beat        <= beat_n;
            write_ready <= (state_n == WRSEQ_IDLE) || (state_n == WRSEQ_POST);
            write_busy  <= (state_n != WRSEQ_IDLE);
            if (write_start && !write_ready)
                overlap_err <= 1'b1;
            di_ack <= ack_n;
            if (di_ack) begin
                dq_d0 <= di[8*BYTES-1:0];
                dq_d1 <= di[16*BYTES-1:8*BYTES];
            end
            if (state_n == WRSEQ_DATA) begin
                dm_d0 <= dmi[BYTES-1:0];
                dm_d1 <= dmi[2*BYTES-1:BYTES];
                dqs_d0 <= '1;
            end else begin
                dm_d0 <= '1;
                dm_d1 <= '1;
                dqs_d0 <= '0;
            end
            dqs_d1 <= '0;
            dq_oe  <= (state_n == WRSEQ_DATA);
            dqs_oe <= (state_n == WRSEQ_PRE) || (state_n == WRSEQ_DATA) ||
                      (state_n == WRSEQ_POST);
        end
    end

endmodule

// File: tb/tb_hpdmc_wrseq.sv
// Directed bench for hpdmc_wrseq at BYTES=4, WL=2, BURST_CYCLES=2.
// Outputs are sampled 1 time unit after each rising edge.
module tb_hpdmc_wrseq;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        write_start;
    logic        write_ready;
    logic        write_busy;
    logic        overlap_err;
    logic [63:0] di;
    logic [7:0]  dmi;
    logic        di_ack;
    logic [31:0] dq_d0, dq_d1;
    logic [3:0]  dm_d0, dm_d1, dqs_d0, dqs_d1;
    logic        dq_oe, dqs_oe;

    int passed = 0;
    int total  = 0;
    int acks;

    hpdmc_wrseq #(.BYTES(4), .WL(2), .BURST_CYCLES(2)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .write_start (write_start),
        .write_ready (write_ready),
        .write_busy  (write_busy),
        .overlap_err (overlap_err),
        .di          (di),
        .dmi         (dmi),
        .di_ack      (di_ack),
        .dq_d0       (dq_d0),
        .dq_d1       (dq_d1),
        .dm_d0       (dm_d0),
        .dm_d1       (dm_d1),
        .dqs_d0      (dqs_d0),
        .dqs_d1      (dqs_d1),
        .dq_oe       (dq_oe),
        .dqs_oe      (dqs_oe)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    initial begin
        sys_rst     = 1'b1;
        write_start = 1'b0;
        di          = '0;
        dmi         = '0;
        step();
        step();
        chk("rst_busy", write_busy, 0);
        chk("rst_ready", write_ready, 1);
        chk("rst_ovl", overlap_err, 0);
        chk("rst_ack", di_ack, 0);
        chk("rst_oe", {dq_oe, dqs_oe}, 0);
        chk("rst_dq", {dq_d0, dq_d1}, 0);
        chk("rst_dqs", {dqs_d0, dqs_d1}, 0);
        chk("rst_dm", {dm_d0, dm_d1}, 8'hFF);
        sys_rst = 1'b0;

        // single write: t0
        write_start = 1'b1;
        step(); // t1 WAIT
        write_start = 1'b0;
        chk("t1_busy", write_busy, 1);
        chk("t1_ack", di_ack, 0);
        chk("t1_dqsoe", dqs_oe, 0);
        step(); // t2 PRE
        chk("t2_ack", di_ack, 1);
        chk("t2_oe", {dq_oe, dqs_oe}, 2'b01);
        chk("t2_dqs", dqs_d0, 0);
        chk("t2_ready", write_ready, 0);
        di  = {32'hBBBBBBBB, 32'hAAAAAAAA};
        dmi = 8'h00;
        step(); // t3 DATA
        chk("t3_ack", di_ack, 1);
        chk("t3_oe", {dq_oe, dqs_oe}, 2'b11);
        chk("t3_dqs", {dqs_d0, dqs_d1}, 8'hF0);
        chk("t3_dq0", dq_d0, 32'hAAAAAAAA);
        chk("t3_dq1", dq_d1, 32'hBBBBBBBB);
        chk("t3_dm", {dm_d0, dm_d1}, 8'h00);
        di  = {32'h22222222, 32'h11111111};
        dmi = 8'h0F;
        step(); // t4 DATA (last)
        chk("t4_ack", di_ack, 0);
        chk("t4_oe", {dq_oe, dqs_oe}, 2'b11);
        chk("t4_dqs", dqs_d0, 4'hF);
        chk("t4_dq", {dq_d1, dq_d0}, 64'h22222222_11111111);
        chk("t4_dm0", dm_d0, 4'hF);
        chk("t4_dm1", dm_d1, 4'h0);
        di  = 64'hDEADBEEF_CAFEF00D;
        dmi = 8'h00;
        step(); // t5 POST
        chk("t5_oe", {dq_oe, dqs_oe}, 2'b01);
        chk("t5_dqs", dqs_d0, 0);
        chk("t5_dm", {dm_d0, dm_d1}, 8'hFF);
        chk("t5_dqhold", dq_d0, 32'h11111111);
        chk("t5_ready", write_ready, 1);
        chk("t5_ack", di_ack, 0);
        step(); // t6 IDLE
        chk("t6_busy", write_busy, 0);
        chk("t6_dqsoe", dqs_oe, 0);
        step();

        // back-to-back: second start in POST (t5)
        acks = 0;
        write_start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            step();
            write_start = (c == 5);
            if (di_ack) acks++;
            if (c == 6) chk("b2b_t6_dqsoe", dqs_oe, 0);
            if (c == 7) chk("b2b_t7_pre", {di_ack, dqs_oe, dq_oe}, 3'b110);
        end
        chk("b2b_acks", acks, 4);
        chk("b2b_ovl", overlap_err, 0);
        chk("b2b_idle", write_busy, 0);

        // overlap: start during DATA at t3
        write_start = 1'b1;
        step(); // t1
        write_start = 1'b0;
        step(); // t2
        step(); // t3
        write_start = 1'b1;
        step(); // t4
        write_start = 1'b0;
        chk("ovl_set", overlap_err, 1);
        chk("ovl_t4", {dq_oe, dqs_oe, di_ack}, 3'b110);
        step(); // t5
        chk("ovl_t5", {dq_oe, dqs_oe, write_ready}, 3'b011);
        step(); // t6
        chk("ovl_t6_idle", write_busy, 0);
        step();
        step();
        chk("ovl_sticky", overlap_err, 1);
        sys_rst     = 1'b1;
        write_start = 1'b1;
        step();
        sys_rst     = 1'b0;
        write_start = 1'b0;
        chk("ovl_clr", overlap_err, 0);
        chk("rst_drop", write_busy, 0);
        step();
        chk("rst_drop2", write_busy, 0);

        // reset mid-DATA at t3
        write_start = 1'b1;
        step(); // t1
        write_start = 1'b0;
        step(); // t2
        step(); // t3
        chk("mr_t3_data", dq_oe, 1);
        sys_rst = 1'b1;
        step(); // t4
        sys_rst = 1'b0;
        chk("mr_busy", write_busy, 0);
        chk("mr_oe", {dq_oe, dqs_oe}, 0);
        chk("mr_dm", {dm_d0, dm_d1}, 8'hFF);
        chk("mr_ack", di_ack, 0);
        write_start = 1'b1;
        step(); // t5 WAIT
        write_start = 1'b0;
        chk("mr_restart", {write_busy, di_ack}, 2'b10);
        step(); // t6 PRE
        chk("mr_pre", {di_ack, dqs_oe}, 2'b11);
        step();
        step();
        step(); // t9 POST
        chk("mr_post", {dqs_oe, dq_oe, write_ready}, 3'b101);
        step(); // t10 IDLE
        chk("mr_idle", write_busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
